// File: rtl/sipo_pkg.sv
// Shared types and sizing helpers for the serial-in parallel-out receiver.
package sipo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 32;

    // Bit counter must hold 0..WIDTH, hence clog2(WIDTH+1).
    function automatic int CNT_W(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register and bit counter; flags the bit_en edge that completes a word
// and presents the completed word combinationally on that same edge.
module sipo_shift_core
    import sipo_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             bit_en,
    input  logic             serial_in,
    input  logic             frame_start,
    input  logic             in_shift,
    output logic             word_done,
    output logic [WIDTH-1:0] word
);

    localparam int CW = CNT_W(WIDTH);

    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] w_base;
    logic [WIDTH-1:0] w_next;
    logic             w_restart;
    logic             w_take;

    // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        w_restart = bit_en & frame_start;
        w_take    = bit_en & (frame_start | in_shift);
        // A frame_start discards whatever partial word is in flight.
        w_base    = w_restart ? '0 : r_shift;
        if (MSB_FIRST) begin
            w_next = {w_base[WIDTH-2:0], serial_in};
        end else begin
            w_next = {serial_in, w_base[WIDTH-1:1]};
        end
        word_done = bit_en & in_shift & ~frame_start & (r_cnt == CW'(WIDTH - 1));
        word      = w_next;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_take) begin
            r_shift <= w_next;
            if (word_done) begin
                r_cnt <= '0;
            end else if (w_restart) begin
                r_cnt <= CW'(1);
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sipo_receiver_32bit.sv
// Framed serial word receiver: IDLE/SHIFT FSM, valid/ready holding register
// and sticky overrun / resync error flags around sipo_shift_core.
module sipo_receiver_32bit
    import sipo_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             bit_en,
    input  logic             serial_in,
    input  logic             frame_start,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             overrun,
    output logic             resync_err,
    input  logic             clear_err,
    output logic             busy
);

    state_t           r_state;
    state_t           w_state_next;
    logic             w_word_done;
    logic [WIDTH-1:0] w_word;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_overrun;
    logic             r_resync;
    logic             w_load;
    logic             w_drop;
    logic             w_consume;
    logic             w_resync_set;

    sipo_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clock       (clock),
        .reset_n     (reset_n),
        .bit_en      (bit_en),
        .serial_in   (serial_in),
        .frame_start (frame_start),
        .in_shift    (r_state == SHIFT),
        .word_done   (w_word_done),
        .word        (w_word)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bit_en && frame_start) w_state_next = SHIFT;
            SHIFT:   if (w_word_done) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        // A consumer taking the old word on the completion edge frees the slot.
        w_load       = w_word_done & (~r_valid | data_ready);
        w_drop       = w_word_done & r_valid & ~data_ready;
        w_consume    = r_valid & data_ready;
        w_resync_set = bit_en & frame_start & (r_state == SHIFT);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_resync  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_data  <= w_word;
                r_valid <= 1'b1;
            end else if (w_consume) begin
                r_valid <= 1'b0;
            end
            // Setting an error wins over clear_err on the same edge.
            r_overrun <= w_drop | (r_overrun & ~clear_err);
            r_resync  <= w_resync_set | (r_resync & ~clear_err);
        end
    end

    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign overrun    = r_overrun;
    assign resync_err = r_resync;
    assign busy       = (r_state == SHIFT);

endmodule
